// File: rtl/de_reg_pkg.sv
// Shared pipeline header: forwarding selects, result classes, opcode/funct
// constants and the small decode record passed between pipeline registers.
package de_reg_pkg;

  // Forwarding mux selects.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;

  // Result class of an instruction: where its write-back value comes from.
  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes.
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  // Link register.
  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] res;
    logic [1:0] tnew;
  } dec_t;

  // Cycles from entering E until the result can be forwarded.
  function automatic logic [1:0] tnew_of(input logic [1:0] res);
    case (res)
      RES_ALU: tnew_of = 2'd1;
      RES_DM:  tnew_of = 2'd2;
      default: tnew_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/wa_res_dec.sv
// Write-address / result-class / tnew decoder, shared by the E, M and W
// pipeline registers.
module wa_res_dec
  import de_reg_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] wa_raw;
  logic [1:0] res_raw;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // rs and shamt do not affect the destination decode.
  logic unused_bits;
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // Raw destination and result class from opcode/funct.
  always_comb begin
    wa_raw  = 5'd0;
    res_raw = RES_NW;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADDU, FUNCT_SUBU: begin
            wa_raw  = rd;
            res_raw = RES_ALU;
          end
          FUNCT_JALR: begin
            wa_raw  = rd;
            res_raw = RES_PC;
          end
          default: begin
            wa_raw  = 5'd0;
            res_raw = RES_NW;
          end
        endcase
      end
      OP_ORI, OP_LUI: begin
        wa_raw  = rt;
        res_raw = RES_ALU;
      end
      OP_LW: begin
        wa_raw  = rt;
        res_raw = RES_DM;
      end
      OP_JAL: begin
        wa_raw  = REG_RA;
        res_raw = RES_PC;
      end
      default: begin
        wa_raw  = 5'd0;
        res_raw = RES_NW;
      end
    endcase
  end

  // Writes to $0 are discarded, so they produce nothing to forward.
  always_comb begin
    dec.wa   = wa_raw;
    dec.res  = (wa_raw == 5'd0) ? RES_NW : res_raw;
    dec.tnew = tnew_of(dec.res);
  end

endmodule

// File: rtl/de_reg.sv
// D/E pipeline register: captures D-stage operands and decoded hazard info,
// inserts a bubble on stall or flush, and counts bubbles with saturation.
module de_reg
  import de_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc8_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] ext_d,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_e,
  output logic [31:0] pc8_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] ext_e,
  output logic [4:0]  ra1_e,
  output logic [4:0]  ra2_e,
  output logic [4:0]  wa_e,
  output logic [1:0]  res_e,
  output logic [1:0]  tnew_e,
  output logic [15:0] bubble_cnt
);

  dec_t dec_d;
  logic bubble;

  assign bubble = stall | flush;

  wa_res_dec u_dec (
    .instr (instr_d),
    .dec   (dec_d)
  );

  // Pipeline state: load D values, or zeros (a nop) when bubbling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_e <= '0;
      pc8_e   <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      ext_e   <= '0;
      ra1_e   <= '0;
      ra2_e   <= '0;
      wa_e    <= '0;
      res_e   <= RES_NW;
      tnew_e  <= '0;
    end else if (bubble) begin
      instr_e <= '0;
      pc8_e   <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      ext_e   <= '0;
      ra1_e   <= '0;
      ra2_e   <= '0;
      wa_e    <= '0;
      res_e   <= RES_NW;
      tnew_e  <= '0;
    end else begin
      instr_e <= instr_d;
      pc8_e   <= pc8_d;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
      ext_e   <= ext_d;
      ra1_e   <= instr_d[25:21];
      ra2_e   <= instr_d[20:16];
      wa_e    <= dec_d.wa;
      res_e   <= dec_d.res;
      tnew_e  <= dec_d.tnew;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
